// File: rtl/multiply_pkg.sv
// Shared types for the multiplier arbiter and its helpers.
// State encoding, operand pair layout and product width rule.
package multiply_pkg;

  localparam int ARGW_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic [1:0][ARGW_DFLT-1:0] pair_t;

  function automatic int resw(input int argw);
    return 2 * argw;
  endfunction

endpackage

// File: rtl/multiply_arbiter_round_robin.sv
// Combinational rotating-priority picker.
// Grants the lowest-index request at or after ptr, wrapping.
module round_robin #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int          jj;
      logic [IW-1:0] j;
      jj = (int'(ptr) + k) % N;
      j  = IW'(jj);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/multiply_arbiter.sv
// Round-robin sharing of one multiplier among REQC requesters.
// One transaction in flight: accept, issue args, wait, respond.
module multiply_arbiter
  import multiply_pkg::*;
#(
  parameter  int ARGW = ARGW_DFLT,
  parameter  int REQC = 4,
  localparam int RESW = resw(ARGW)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQC-1:0][2*ARGW-1:0]    req_data,
  input  logic [REQC-1:0]                req_valid,
  output logic [REQC-1:0]                req_ready,
  output logic [RESW-1:0]                rsp_data,
  output logic [REQC-1:0]                rsp_valid,
  input  logic [REQC-1:0]                rsp_ready,
  output logic [1:0][ARGW-1:0]           arg_data,
  output logic [1:0]                     arg_valid,
  input  logic [1:0]                     arg_ready,
  input  logic [RESW-1:0]                res_data,
  input  logic                           res_valid,
  output logic                           res_ready
);

  localparam int IW = $clog2(REQC);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       g;
  logic [1:0]          sent;
  logic [1:0]          sent_nxt;
  logic [1:0][ARGW-1:0] pair;
  logic [RESW-1:0]     prod;

  logic [REQC-1:0]     gnt;
  logic [IW-1:0]       idx;
  logic                any;

  round_robin #(
    .N  (REQC),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // req_ready is combinational, so mask it while reset is held
  always_comb begin
    req_ready = '0;
    arg_valid = '0;
    res_ready = 1'b0;
    rsp_valid = '0;
    unique case (state)
      IDLE:    req_ready = rst ? gnt : '0;
      ISSUE:   arg_valid = ~sent;
      WAIT:    res_ready = 1'b1;
      RESP:    rsp_valid[g] = 1'b1;
      default: ;
    endcase
  end

  assign sent_nxt = sent | (arg_valid & arg_ready);
  assign arg_data = pair;
  assign rsp_data = prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      sent  <= '0;
      pair  <= '0;
      prod  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            pair  <= req_data[idx];
            g     <= idx;
            sent  <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          sent <= sent_nxt;
          if (&sent_nxt) state <= WAIT;
        end
        WAIT: begin
          if (res_valid) begin
            prod  <= res_data;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[g]) begin
            ptr   <= (g == IW'(REQC - 1)) ? '0 : g + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter: multiplier model, requester queues,
// scoreboard of grant order and products, plus directed corners.
module tb_multiply_arbiter;

  localparam int ARGW = 16;
  localparam int REQC = 4;
  localparam int RESW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [REQC-1:0][2*ARGW-1:0] req_data;
  logic [REQC-1:0]             req_valid;
  logic [REQC-1:0]             req_ready;
  logic [RESW-1:0]             rsp_data;
  logic [REQC-1:0]             rsp_valid;
  logic [REQC-1:0]             rsp_ready;
  logic [1:0][ARGW-1:0]        arg_data;
  logic [1:0]                  arg_valid;
  logic [1:0]                  arg_ready;
  logic [RESW-1:0]             res_data;
  logic                        res_valid = 1'b0;
  logic                        res_ready;

  multiply_arbiter #(.ARGW(ARGW), .REQC(REQC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .arg_data  (arg_data),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier model: independent arg channels, fixed latency, signed product
  logic [1:0]      got = '0;
  logic [ARGW-1:0] op0, op1;
  int              cnt = 0;
  int              mlat = 2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      got       <= '0;
      cnt       <= 0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (arg_valid[0] && arg_ready[0]) begin
        op0    <= arg_data[0];
        got[0] <= 1'b1;
      end
      if (arg_valid[1] && arg_ready[1]) begin
        op1    <= arg_data[1];
        got[1] <= 1'b1;
      end
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (got == 2'b11) begin
        if (cnt >= mlat) begin
          res_valid <= 1'b1;
          res_data  <= $signed(op0) * $signed(op1);
          got       <= '0;
          cnt       <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Requester side: per-requester queues of pending operand pairs
  logic [31:0]     pend[REQC][$];
  logic [REQC-1:0] hs = '0;
  bit              rnd_mode = 1'b0;
  logic [REQC-1:0] rsp_rdy_set = '1;
  logic [1:0]      arg_rdy_set = '1;

  initial begin
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '1;
    arg_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < REQC; r++) begin
        if (hs[r] && pend[r].size() > 0) void'(pend[r].pop_front());
        if (pend[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_data[r]  = pend[r][0];
        end else begin
          req_valid[r] = 1'b0;
          req_data[r]  = '0;
        end
      end
      rsp_ready = rnd_mode ? REQC'($urandom) : rsp_rdy_set;
      arg_ready = rnd_mode ? 2'($urandom_range(0, 3)) : arg_rdy_set;
    end
  end

  // Reference model: rotating grant order and expected products
  typedef struct {
    int          who;
    logic [31:0] val;
  } exp_t;

  exp_t               exp_q[$];
  int                 mptr = 0;
  bit                 busy = 1'b0;
  int                 gnt_log[$];
  int                 rsp_who_log[$];
  logic [31:0]        rsp_val_log[$];
  int                 mr, mp;
  logic signed [31:0] mprod;
  exp_t               e;

  always @(negedge clk) begin
    if (!rst) begin
      hs   = '0;
      exp_q.delete();
      mptr = 0;
      busy = 1'b0;
    end else begin
      hs = req_valid & req_ready;
      chk("onehot", {30'b0, $countones(req_ready) > 1,
                     $countones(rsp_valid) > 1}, 32'd0);
      if (|hs) begin
        mr = -1;
        mp = -1;
        for (int k = 0; k < REQC; k++)
          if (hs[k] && mr < 0) mr = k;
        for (int k = 0; k < REQC; k++)
          if (req_valid[(mptr + k) % REQC] && mp < 0) mp = (mptr + k) % REQC;
        chk("grant_order", mr, mp);
        chk("grant_busy", {31'b0, busy}, 32'd0);
        mprod = $signed(req_data[mr][15:0]) * $signed(req_data[mr][31:16]);
        exp_q.push_back('{mr, mprod});
        gnt_log.push_back(mr);
        busy = 1'b1;
      end
      if (|rsp_valid && !busy) chk("spurious_rsp", {28'b0, rsp_valid}, 32'd0);
      for (int k = 0; k < REQC; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", k, 32'd99);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_who", k, e.who);
            chk("rsp_data", rsp_data, e.val);
            rsp_who_log.push_back(k);
            rsp_val_log.push_back(rsp_data);
            mptr = (k + 1) % REQC;
            busy = 1'b0;
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    bit ok;
    ok = !busy && (req_valid == '0);
    for (int r = 0; r < REQC; r++)
      if (pend[r].size() != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      done = all_idle();
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  function automatic int last_who();
    return (rsp_who_log.size() > 0) ? rsp_who_log[rsp_who_log.size()-1] : -1;
  endfunction

  function automatic logic [31:0] last_val();
    return (rsp_val_log.size() > 0) ? rsp_val_log[rsp_val_log.size()-1]
                                    : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_req_ready"}, {28'b0, req_ready}, 32'd0);
    chk({nm, "_rsp_valid"}, {28'b0, rsp_valid}, 32'd0);
    chk({nm, "_arg_valid"}, {30'b0, arg_valid}, 32'd0);
    chk({nm, "_res_ready"}, {31'b0, res_ready}, 32'd0);
    chk({nm, "_rsp_data"}, rsp_data, 32'd0);
  endtask

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int nb, m0, pos, seen;

    tbl[0] = '{0, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA};
    tbl[1] = '{1, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[2] = '{2, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    tbl[3] = '{0, 16'h7FFF, 16'h8000, 32'hC000_8000};
    tbl[4] = '{1, 16'h8000, 16'h7FFF, 32'hC000_8000};
    tbl[5] = '{2, 16'h0000, 16'h1234, 32'h0000_0000};
    tbl[6] = '{3, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};

    // Reset state, with a request already pending on requester 1
    rst = 1'b0;
    pend[1].push_back({16'd6, 16'd7});
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b1;
    wait_idle(60);
    chk("first_who", last_who(), 1);
    chk("first_val", last_val(), 32'd42);

    // Directed vectors, incl. sign extremes
    for (int i = 0; i < 7; i++) begin
      pend[tbl[i].r].push_back({tbl[i].b, tbl[i].a});
      wait_idle(60);
      chk($sformatf("vec%0d_who", i), last_who(), tbl[i].r);
      chk($sformatf("vec%0d_val", i), last_val(), tbl[i].exp);
    end

    // Two bursts with every requester valid: order 0,1,2,3 each time
    for (int b = 0; b < 2; b++) begin
      nb = rsp_who_log.size();
      for (int k = 0; k < REQC; k++) begin
        if (b == 0) pend[k].push_back({16'(k + 1), 16'(k + 1)});
        else pend[k].push_back({16'd10, 16'(-(k + 1))});
      end
      wait_idle(200);
      chk($sformatf("burst%0d_cnt", b), rsp_who_log.size(), nb + REQC);
      for (int k = 0; k < REQC && nb + k < rsp_who_log.size(); k++) begin
        chk($sformatf("burst%0d_who%0d", b, k), rsp_who_log[nb + k], k);
        chk($sformatf("burst%0d_val%0d", b, k), rsp_val_log[nb + k],
            (b == 0) ? 32'((k + 1) * (k + 1)) : 32'(-10 * (k + 1)));
      end
    end

    // Backpressure on arg channel 1 and on requester 2's response
    arg_rdy_set = 2'b01;
    rsp_rdy_set = 4'b1011;
    pend[2].push_back({16'hFFF9, 16'd5});
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (arg_valid[1]) seen = 1;
    end
    chk("bp_arg_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_arg_valid", {30'b0, arg_valid}, 32'd2);
      chk("bp_arg_data1", {16'b0, arg_data[1]}, 32'h0000_FFF9);
    end
    arg_rdy_set = 2'b11;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1;
    end
    chk("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {28'b0, rsp_valid}, 32'd4);
      chk("bp_rsp_data", rsp_data, 32'hFFFF_FFDD);
      @(negedge clk);
    end
    rsp_rdy_set = '1;
    wait_idle(60);
    chk("bp_who", last_who(), 2);
    chk("bp_val", last_val(), 32'hFFFF_FFDD);

    // Fairness: requester 3 gets in right behind a streaming requester 1
    for (int i = 0; i < 4; i++) pend[1].push_back({16'(i + 2), 16'd3});
    repeat (2) @(negedge clk);
    m0 = gnt_log.size();
    pend[3].push_back({16'd4, 16'd4});
    wait_idle(300);
    pos = 1000;
    for (int i = gnt_log.size() - 1; i >= m0; i--)
      if (gnt_log[i] == 3) pos = i - m0;
    chk("fair_wait", {31'b0, pos <= 1}, 32'd1);

    // Randomized traffic with random stalls on both sides
    rnd_mode = 1'b1;
    nb = rsp_who_log.size();
    for (int i = 0; i < 40; i++) begin
      pend[$urandom_range(0, REQC - 1)].push_back($urandom);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_idle(4000);
    rnd_mode = 1'b0;
    chk("rand_cnt", rsp_who_log.size(), nb + 40);

    // Reset during WAIT: aborted request yields nothing, ptr restarts at 0
    pend[1].push_back({16'd3, 16'd2});
    wait_idle(60);
    pend[2].push_back({16'd9, 16'd9});
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (res_ready) seen = 1;
    end
    chk("rst_wait_seen", seen, 1);
    rst = 1'b0;
    #1;
    chk_outs_zero("midrst");
    nb = rsp_who_log.size();
    pend[3].push_back({16'd12, 16'd11});
    pend[0].push_back({16'd5, 16'hFFFC});
    repeat (2) @(negedge clk);
    chk_outs_zero("midrst_hold");
    rst = 1'b1;
    wait_idle(100);
    chk("rst_cnt", rsp_who_log.size(), nb + 2);
    if (rsp_who_log.size() >= nb + 2) begin
      chk("rst_who0", rsp_who_log[nb], 0);
      chk("rst_val0", rsp_val_log[nb], 32'hFFFF_FFEC);
      chk("rst_who1", rsp_who_log[nb + 1], 3);
      chk("rst_val1", rsp_val_log[nb + 1], 32'd132);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multiply_arbiter.md
# multiply_arbiter

Shares one `multiply` instance among `REQC` requesters. Each requester presents a signed operand pair on its own valid/ready channel. The arbiter grants requesters round-robin, issues the pair to the multiplier's two argument channels, collects the product, and returns it on the granted requester's response channel. It sits between the requesting datapath units and the single multiplier; one transaction is in flight at a time.

## Interface

Parameters:
- `ARGW`, 16, operand width; product width `RESW = 2*ARGW`.
- `REQC`, 4, number of requesters; range 2..16.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_data` in `REQC` x `2*ARGW`: operand pair per requester; `[ARGW-1:0]` is operand 0, `[2*ARGW-1:ARGW]` is operand 1.
- `req_valid` in `REQC`: request valid per requester.
- `req_ready` out `REQC`: request accepted; at most one bit set.
- `rsp_data` out `RESW`: product, shared by all requesters.
- `rsp_valid` out `REQC`: response valid; at most one bit set.
- `rsp_ready` in `REQC`: response ready per requester.
- `arg_data` out 2 x `ARGW`: multiplier argument channels 0 and 1.
- `arg_valid` out 2: multiplier argument valid.
- `arg_ready` in 2: multiplier argument ready.
- `res_data` in `RESW`: multiplier product.
- `res_valid` in 1: multiplier product valid.
- `res_ready` out 1: multiplier product ready.

## Operation

State machine states and transitions:
- **IDLE**: grant the lowest-index valid requester at or after `ptr`, wrapping. Assert `req_ready[g]` combinationally. On handshake, latch the operand pair and `g`, clear `sent[1:0]`, go to ISSUE. No valid requester: stay in IDLE.
- **ISSUE**: for each `i` with `sent[i]=0`, drive `arg_valid[i]=1` and `arg_data[i]` = latched operand `i`. On the `arg_valid[i] & arg_ready[i]` handshake, set `sent[i]`. The two channels complete independently and in either order, including the same cycle. When both are sent, go to WAIT.
- **WAIT**: `res_ready=1`. On `res_valid`, latch `res_data` and go to RESP.
- **RESP**: `rsp_valid[g]=1` and `rsp_data` = latched product. On `rsp_ready[g]`, set `ptr = (g+1) mod REQC` and go to IDLE.

General rules:
- The arbiter performs no arithmetic; the sign and width of the product are exactly as produced by `multiply`.
- `rsp_data` is the held product in RESP and don't-care otherwise. It is driven to 0 at reset and only updates in WAIT.
- A requester holds `req_valid` and `req_data` stable until its `req_ready` is asserted. A requester holds `rsp_ready` behaviour independent of other requesters.
- Requests from non-granted requesters wait. No request is ever dropped and none is accepted twice.

## Timing

- Reset (`rst` low, asynchronous):
  - state becomes IDLE and `ptr` becomes 0.
  - All `req_ready`, `rsp_valid`, `arg_valid` and `res_ready` go to 0, and `rsp_data` to 0.
  - An in-flight transaction is discarded without a response. The multiplier shares `rst`, so its pending result is also discarded.
- Request accept is combinational in IDLE. Operands appear on `arg_*` in the cycle after the `req` handshake.
- Minimum latency from `req` handshake to `rsp_valid` is 3 cycles plus the multiplier latency: 1 cycle ISSUE, WAIT until `res_valid`, then 1 cycle to register into RESP.
- Throughput is at most one transaction per (multiplier latency + 4) cycles. A new grant cannot occur in the same cycle as the `rsp` handshake.
- Backpressure:
  - `arg_ready` low: hold the unsent channel.
  - `rsp_ready` low: hold RESP indefinitely. Other requesters are not served meanwhile.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,`REQC-1`,0. A requester waits at most `REQC-1` transactions.
- `req_valid[g]` dropping after accept has no effect. `rsp_ready` on non-granted requesters is ignored.

## Structure

- Shared package `multiply_pkg`:
  - `state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `RESW` derivation.
  - operand-pair typedef `pair_t` (packed 2 x `ARGW`).
- Sub-module `round_robin #(N)`:
  - inputs `req[N]` and `ptr`.
  - outputs one-hot `gnt`, index `idx` and `any`.
  - purely combinational; reusable by other shared-resource arbiters.
- The arbiter holds the registers `state`, `ptr`, `g`, `sent`, the operand pair and the product.

## Test plan

- **Single requester**: requester 0 sends (3, -2), i.e. `16'h0003` and `16'hFFFE` → `rsp_valid[0]` with `rsp_data=32'hFFFF_FFFA`. No other `rsp_valid` bit is ever set.
- **All four valid at once**: operands (1,1), (2,2), (3,3), (4,4) on requesters 0–3 → responses in order 0,1,2,3 with 1, 4, 9, 16. A second burst is then served starting from requester 0 again, since `ptr` wrapped.
- **Extremes**:
  - (`16'h8000`, `16'h8000`) → `32'h4000_0000`.
  - (`16'hFFFF`, `16'hFFFF`) → `32'h0000_0001`.
  - (`16'h7FFF`, `16'h8000`) → `32'hC000_8000`.
- **Backpressure**: `arg_ready[1]` held low 5 cycles while `arg_ready[0]` is high, and `rsp_ready[2]` held low 10 cycles → product is still correct; `rsp_valid[2]` is held stable with unchanged data.
- **Fairness**: requester 1 issues continuous requests while requester 3 issues one → requester 3 is served no later than the second grant after its `req_valid` rises.
- **Reset mid-operation**: drop `rst` during WAIT, then release → all outputs are 0 during reset, no response is issued for the aborted request, and the next request is served from requester 0 priority with the correct product.
